// File: rtl/apb_slave_mem.sv
// APB scratch-memory target with programmable wait states, byte strobes,
// out-of-range / injected SLVERR, saturating transfer statistics and a sticky protocol flag.
module apb_slave_mem #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                WAIT_W    = 4,
    parameter int                CNT_W     = 16
) (
    input  logic                  apb_clk_i,
    input  logic                  apb_reset_i,
    input  logic [ADDR_W-1:0]     apb_addr_i,
    input  logic                  apb_sel_i,
    input  logic                  apb_enable_i,
    input  logic                  apb_write_i,
    input  logic [DATA_W/8-1:0]   apb_strb_i,
    input  logic [2:0]            apb_prot_i,
    input  logic [DATA_W-1:0]     apb_wdata_i,
    output logic                  apb_ready_o,
    output logic [DATA_W-1:0]     apb_rdata_o,
    output logic                  apb_slverr_o,
    input  logic [WAIT_W-1:0]     wait_cfg_i,
    input  logic                  err_inject_i,
    output logic [CNT_W-1:0]      wr_count_o,
    output logic [CNT_W-1:0]      rd_count_o,
    output logic [CNT_W-1:0]      err_count_o,
    output logic                  proto_err_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                proto_q, proto_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [ADDR_W-1:0]   off;
    logic [ADDR_W-1:0]   idx_full;
    logic [IDX_W-1:0]    idx;
    logic                hit;
    logic                unused_prot;

    assign unused_prot = ^apb_prot_i;

    // Low address bits below the word size are dropped, so misaligned accesses just hit the word.
    assign off      = apb_addr_i - BASE_ADDR;
    assign idx_full = off >> OFF_W;
    assign hit      = (apb_addr_i >= BASE_ADDR) && (idx_full < DEPTH_A);
    assign idx      = idx_full[IDX_W-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        write_d   = write_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        proto_d   = proto_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (apb_sel_i && !apb_enable_i) begin
                    state_d = ACCESS;
                    cnt_d   = wait_cfg_i;
                    err_d   = !hit || err_inject_i;
                    write_d = apb_write_i;
                    idx_d   = idx;
                    if (!apb_write_i) rdata_d = err_d ? '0 : mem_q[idx];
                end else if (apb_sel_i && apb_enable_i) begin
                    proto_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!apb_sel_i) begin
                    // Master abandoned the transfer: flag it and drop it without side effects.
                    proto_d = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    if (apb_enable_i) cnt_d = cnt_q - WAIT_W'(1);
                end else if (apb_enable_i) begin
                    state_d = IDLE;
                    if (err_q)        err_cnt_d = sat_inc(err_cnt_q);
                    else if (write_q) begin
                        wr_cnt_d = sat_inc(wr_cnt_q);
                        mem_we   = 1'b1;
                    end else          rd_cnt_d = sat_inc(rd_cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge apb_clk_i) begin
        if (apb_reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            rdata_q   <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
            proto_q   <= proto_d;
        end
    end

    // Storage is deliberately not reset so contents survive a bus reset.
    always_ff @(posedge apb_clk_i) begin
        if (mem_we && !apb_reset_i) begin
            for (int b = 0; b < NB; b++) begin
                if (apb_strb_i[b]) mem_q[idx_q][b*8 +: 8] <= apb_wdata_i[b*8 +: 8];
            end
        end
    end

    assign apb_ready_o  = (state_q == ACCESS) && (cnt_q == '0);
    assign apb_slverr_o = apb_ready_o && err_q;
    assign apb_rdata_o  = rdata_q;
    assign wr_count_o   = wr_cnt_q;
    assign rd_count_o   = rd_cnt_q;
    assign err_count_o  = err_cnt_q;
    assign proto_err_o  = proto_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: directed vector table, multi-cycle corner sequences and
// randomized traffic against a word-array reference model.
module tb_apb_slave_mem;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          DEP  = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        sel = 1'b0, en = 1'b0, wr = 1'b0, inj = 1'b0;
    logic [3:0]  strb = '0, wait_cfg = '0;
    logic [2:0]  prot = '0;
    logic [31:0] wdata = '0;

    logic        ready, slverr, proto;
    logic [31:0] rdata;
    logic [15:0] wr_cnt, rd_cnt, err_cnt;
    logic        s_ready, s_slverr, s_proto;
    logic [31:0] s_rdata;
    logic [1:0]  s_wr_cnt, s_rd_cnt, s_err_cnt;

    always #5 clk = ~clk;

    apb_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .BASE_ADDR(BASE), .WAIT_W(4), .CNT_W(16)) u_dut (
        .apb_clk_i(clk), .apb_reset_i(rst), .apb_addr_i(addr), .apb_sel_i(sel), .apb_enable_i(en),
        .apb_write_i(wr), .apb_strb_i(strb), .apb_prot_i(prot), .apb_wdata_i(wdata),
        .apb_ready_o(ready), .apb_rdata_o(rdata), .apb_slverr_o(slverr),
        .wait_cfg_i(wait_cfg), .err_inject_i(inj),
        .wr_count_o(wr_cnt), .rd_count_o(rd_cnt), .err_count_o(err_cnt), .proto_err_o(proto));

    apb_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .BASE_ADDR(BASE), .WAIT_W(4), .CNT_W(2)) u_sat (
        .apb_clk_i(clk), .apb_reset_i(rst), .apb_addr_i(addr), .apb_sel_i(sel), .apb_enable_i(en),
        .apb_write_i(wr), .apb_strb_i(strb), .apb_prot_i(prot), .apb_wdata_i(wdata),
        .apb_ready_o(s_ready), .apb_rdata_o(s_rdata), .apb_slverr_o(s_slverr),
        .wait_cfg_i(wait_cfg), .err_inject_i(inj),
        .wr_count_o(s_wr_cnt), .rd_count_o(s_rd_cnt), .err_count_o(s_err_cnt), .proto_err_o(s_proto));

    int checks = 0;
    int failures = 0;

    // Reference model: plain word array plus unbounded transfer tallies.
    logic [31:0] mdl [DEP];
    logic [31:0] last_rd;
    int m_wr, m_rd, m_err;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          wt;
        bit          ij;
        logic [31:0] erd;
        bit          eslv;
        int          ewr, erdc, eerr;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < DEP);
    endfunction

    task automatic chk_cnt(input string nm);
        chk({nm, " wr_cnt"},  64'(wr_cnt),    64'(sat(m_wr, 65535)));
        chk({nm, " rd_cnt"},  64'(rd_cnt),    64'(sat(m_rd, 65535)));
        chk({nm, " err_cnt"}, 64'(err_cnt),   64'(sat(m_err, 65535)));
        chk({nm, " sat_wr"},  64'(s_wr_cnt),  64'(sat(m_wr, 3)));
        chk({nm, " sat_rd"},  64'(s_rd_cnt),  64'(sat(m_rd, 3)));
        chk({nm, " sat_err"}, 64'(s_err_cnt), 64'(sat(m_err, 3)));
    endtask

    task automatic do_reset();
        sel = 1'b0; en = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_wr = 0; m_rd = 0; m_err = 0; last_rd = '0;
    endtask

    // One full transfer; leaves the bus idle at #1 after the completing edge so a following
    // call issues its setup phase in the very next cycle.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int wt, input bit ij, input string nm,
                        output logic [31:0] rd_o, output logic se_o);
        int n;
        bit e;
        logic [31:0] i;
        e = !in_range(a) || ij;
        i = (a - BASE) >> 2;
        sel = 1'b1; en = 1'b0; wr = w; addr = a; wdata = d; strb = s;
        wait_cfg = 4'(wt); inj = ij;
        @(posedge clk); #1;
        en = 1'b1; inj = 1'b0; wait_cfg = ~wait_cfg;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(wt));
        rd_o = rdata;
        se_o = slverr;
        @(posedge clk); #1;
        sel = 1'b0; en = 1'b0;
        if (e) m_err++;
        else if (w) begin
            m_wr++;
            for (int b = 0; b < 4; b++) if (s[b]) mdl[i[7:0]][b*8 +: 8] = d[b*8 +: 8];
        end else m_rd++;
        if (!w) last_rd = e ? 32'h0 : mdl[i[7:0]];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_v, exp_rd, a;
        logic        se_v;
        bit          w, ij, e;
        logic [3:0]  s;
        int          wt;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst ready", 64'(ready), 0);
        chk("rst slverr", 64'(slverr), 0);
        chk("rst rdata", 64'(rdata), 0);
        chk("rst proto", 64'(proto), 0);
        chk_cnt("rst");
        @(posedge clk); #1;

        // Preload every word back-to-back, then reset: contents must survive.
        for (int k = 0; k < DEP; k++)
            xfer(1'b1, BASE + 32'(k * 4), 32'hC0DE_0000 | 32'(k), 4'hF, 0, 1'b0, "init", rd_v, se_v);
        do_reset();
        @(negedge clk);
        chk("rst2 rdata", 64'(rdata), 0);
        chk_cnt("rst2");
        @(posedge clk); #1;

        tbl[0]  = '{1'b1, BASE + 32'h10,  32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,        1'b0, 1, 0, 0};
        tbl[1]  = '{1'b0, BASE + 32'h10,  32'h0,        4'hF, 0, 1'b0, 32'hDEADBEEF, 1'b0, 1, 1, 0};
        tbl[2]  = '{1'b1, BASE + 32'h20,  32'hFFFFFFFF, 4'hF, 0, 1'b0, 32'h0,        1'b0, 2, 1, 0};
        tbl[3]  = '{1'b1, BASE + 32'h20,  32'h11223344, 4'h5, 3, 1'b0, 32'h0,        1'b0, 3, 1, 0};
        tbl[4]  = '{1'b0, BASE + 32'h20,  32'h0,        4'h0, 1, 1'b0, 32'hFF22FF44, 1'b0, 3, 2, 0};
        tbl[5]  = '{1'b0, BASE + 32'h400, 32'h0,        4'h0, 0, 1'b0, 32'h0,        1'b1, 3, 2, 1};
        tbl[6]  = '{1'b1, BASE + 32'h10,  32'h12345678, 4'hF, 2, 1'b1, 32'h0,        1'b1, 3, 2, 2};
        tbl[7]  = '{1'b0, BASE + 32'h10,  32'h0,        4'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 3, 2};
        tbl[8]  = '{1'b0, BASE + 32'h3FC, 32'h0,        4'h0, 0, 1'b0, 32'hC0DE00FF, 1'b0, 3, 4, 2};
        tbl[9]  = '{1'b0, BASE - 32'h4,   32'h0,        4'h0, 0, 1'b0, 32'h0,        1'b1, 3, 4, 3};
        tbl[10] = '{1'b0, BASE + 32'h13,  32'h0,        4'h0, 2, 1'b0, 32'hDEADBEEF, 1'b0, 3, 5, 3};

        for (int k = 0; k < 11; k++) begin
            xfer(tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].s, tbl[k].wt, tbl[k].ij, $sformatf("vec%0d", k), rd_v, se_v);
            chk($sformatf("vec%0d slverr", k), 64'(se_v), 64'(tbl[k].eslv));
            if (!tbl[k].w) chk($sformatf("vec%0d rdata", k), 64'(rd_v), 64'(tbl[k].erd));
            chk($sformatf("vec%0d wr_cnt", k), 64'(wr_cnt), 64'(tbl[k].ewr));
            chk($sformatf("vec%0d rd_cnt", k), 64'(rd_cnt), 64'(tbl[k].erdc));
            chk($sformatf("vec%0d err_cnt", k), 64'(err_cnt), 64'(tbl[k].eerr));
        end

        // Reset landing in the 2nd access cycle of a 5-wait write
        sel = 1'b1; en = 1'b0; wr = 1'b1; addr = BASE + 32'h30; wdata = 32'hAAAA5555; strb = 4'hF; wait_cfg = 4'd5;
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; sel = 1'b0; en = 1'b0;
        m_wr = 0; m_rd = 0; m_err = 0; last_rd = '0;
        @(negedge clk);
        chk("rstmid ready", 64'(ready), 0);
        chk_cnt("rstmid");
        @(posedge clk); #1;
        xfer(1'b0, BASE + 32'h30, 32'h0, 4'h0, 0, 1'b0, "rstmid rb", rd_v, se_v);
        chk("rstmid readback", 64'(rd_v), 64'(32'hC0DE000C));

        // SEL+ENABLE straight from IDLE
        do_reset();
        chk("proto pre", 64'(proto), 0);
        sel = 1'b1; en = 1'b1; wr = 1'b0; addr = BASE;
        @(negedge clk);
        chk("proto ready0", 64'(ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("proto ready1", 64'(ready), 0);
        chk("proto flag", 64'(proto), 1);
        sel = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        chk("proto sticky", 64'(proto), 1);
        chk_cnt("proto");

        // SEL dropped during access: no write, no count
        do_reset();
        sel = 1'b1; en = 1'b0; wr = 1'b1; addr = BASE + 32'h40; wdata = 32'h0; strb = 4'hF; wait_cfg = 4'd0;
        @(posedge clk); #1;
        sel = 1'b0;
        @(posedge clk); #1;
        chk("abort proto", 64'(proto), 1);
        chk("abort ready", 64'(ready), 0);
        chk_cnt("abort");
        xfer(1'b0, BASE + 32'h40, 32'h0, 4'h0, 0, 1'b0, "abort rb", rd_v, se_v);
        chk("abort readback", 64'(rd_v), 64'(32'hC0DE0010));

        // Counter saturation on the 2-bit instance
        do_reset();
        for (int k = 0; k < 5; k++)
            xfer(1'b1, BASE + 32'h50 + 32'(k * 4), 32'(k), 4'hF, 0, 1'b0, "satw", rd_v, se_v);
        chk("sat wr_cnt", 64'(s_wr_cnt), 3);
        chk("full wr_cnt", 64'(wr_cnt), 5);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 15))
                0: a = BASE + 32'h400 + 32'($urandom_range(0, 255) * 4);
                1: a = BASE - 32'($urandom_range(1, 4) * 4);
                default: a = BASE + 32'($urandom_range(0, 1023));
            endcase
            w  = 1'($urandom_range(0, 1));
            ij = ($urandom_range(0, 7) == 0);
            wt = $urandom_range(0, 3);
            s  = 4'($urandom_range(0, 15));
            wdata = $urandom;
            e = !in_range(a) || ij;
            exp_rd = w ? last_rd : (e ? 32'h0 : mdl[8'((a - BASE) >> 2)]);
            xfer(w, a, wdata, s, wt, ij, "rnd", rd_v, se_v);
            chk("rnd slverr", 64'(se_v), 64'(e));
            chk("rnd rdata", 64'(rd_v), 64'(exp_rd));
            chk_cnt("rnd");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        chk("rnd proto", 64'(proto), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
